// File: rtl/quad_decoder.sv
// Quadrature encoder front end: 2-FF sync, per-channel glitch filter, direction/position decode, illegal-edge flagging.
// Latency FILTER_LEN+3 cycles from input edge to tick; no backpressure, tick/err are free-running one-cycle strobes.
module quad_decoder #(
  parameter int FILTER_LEN  = 4,
  parameter int DECODE_MODE = 4,
  parameter int POS_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clr_pos,
  output logic             tick,
  output logic             dir,
  output logic [POS_W-1:0] position,
  output logic             err,
  output logic [7:0]       err_count
);

  localparam logic [3:0] FLT_LAST  = 4'(FILTER_LEN - 1);
  localparam logic [4:0] INIT_LAST = 5'(FILTER_LEN + 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t     state;
  logic [4:0] init_cnt;
  // Channel vectors are {A, B}.
  logic [1:0] raw, meta, sync, filt, prev;
  logic [3:0] fcnt [2];
  logic       a_chg, b_chg, illegal, legal, fwd, counted;

  assign raw = {enc_a, enc_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (rst) begin
        filt[ch] <= 1'b0;
        fcnt[ch] <= '0;
      end else if (state == INIT) begin
        filt[ch] <= sync[ch];
        fcnt[ch] <= '0;
      end else if (sync[ch] == filt[ch]) begin
        fcnt[ch] <= '0;
      end else if (fcnt[ch] == FLT_LAST) begin
        filt[ch] <= sync[ch];
        fcnt[ch] <= '0;
      end else begin
        fcnt[ch] <= fcnt[ch] + 4'd1;
      end
    end
  end

  // Forward (A leads B) means the new state is {~B_prev, A_prev}.
  always_comb begin
    a_chg   = filt[1] ^ prev[1];
    b_chg   = filt[0] ^ prev[0];
    illegal = a_chg & b_chg;
    legal   = a_chg ^ b_chg;
    fwd     = (filt == {~prev[0], prev[1]});
    counted = 1'b0;
    if (DECODE_MODE == 1)
      counted = legal & a_chg & filt[1];
    else if (DECODE_MODE == 2)
      counted = legal & a_chg;
    else
      counted = legal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      init_cnt  <= '0;
      prev      <= '0;
      tick      <= 1'b0;
      dir       <= 1'b0;
      err       <= 1'b0;
      position  <= '0;
      err_count <= '0;
    end else begin
      tick <= 1'b0;
      err  <= 1'b0;
      case (state)
        INIT: begin
          // Track the synced lines so RUN starts with prev == filt.
          prev <= sync;
          if (init_cnt == INIT_LAST)
            state <= RUN;
          else
            init_cnt <= init_cnt + 5'd1;
        end
        RUN: begin
          prev <= filt;
          if (illegal) begin
            err <= 1'b1;
            if (err_count != 8'hFF)
              err_count <= err_count + 8'd1;
          end
          if (legal)
            dir <= fwd;
          if (counted)
            tick <= 1'b1;
        end
        default: state <= INIT;
      endcase
      if (clr_pos)
        position <= '0;
      else if (state == RUN && counted)
        position <= fwd ? position + POS_W'(1) : position - POS_W'(1);
    end
  end

endmodule
